// File: rtl/gray_lut_builder_pkg.sv
// Shared state encoding, ROI/bank defaults and the gray-level saturation helper
// for the histogram-equalisation table builder.
package gray_lut_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    ACCUM = 2'd2,
    CDF   = 2'd3
  } state_t;

  localparam int BIN_W  = 18;
  localparam int PROD_W = 26;

  localparam logic [9:0]  DEF_ROI_X0      = 10'd104;
  localparam logic [9:0]  DEF_ROI_X1      = 10'd616;
  localparam logic [9:0]  DEF_ROI_Y0      = 10'd30;
  localparam logic [9:0]  DEF_ROI_Y1      = 10'd286;
  localparam int unsigned DEF_ROI_SHIFT   = 17;
  localparam logic [9:0]  DEF_BANK_STRIDE = 10'd512;

  // cdf*255 normalised by the ROI size; clamps if the histogram over-filled.
  function automatic logic [7:0] sat_gray(input logic [PROD_W-1:0] p, input int unsigned shift);
    logic [PROD_W-1:0] q;
    q = p >> shift;
    return (|q[PROD_W-1:8]) ? 8'hFF : q[7:0];
  endfunction

endpackage

// File: rtl/gray_lut_builder_hist_ram.sv
// 256x18 histogram store: synchronous write, registered read (old data on a
// same-address read/write collision), no reset so it maps onto block RAM.
module hist_ram
  import gray_lut_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = BIN_W
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gray_lut_builder.sv
// Builds a luma histogram over the field-0 ROI, then writes the equalisation
// table into the idle gray-table bank; frame_end to lut_done is 259 cycles.
module gray_lut_builder
  import gray_lut_pkg::*;
#(
  parameter logic [9:0]  ROI_X0      = DEF_ROI_X0,
  parameter logic [9:0]  ROI_X1      = DEF_ROI_X1,
  parameter logic [9:0]  ROI_Y0      = DEF_ROI_Y0,
  parameter logic [9:0]  ROI_Y1      = DEF_ROI_Y1,
  parameter int unsigned ROI_SHIFT   = DEF_ROI_SHIFT,
  parameter logic [9:0]  BANK_STRIDE = DEF_BANK_STRIDE
) (
  input  logic        llck,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        flag,
  input  logic        pix_valid,
  input  logic [7:0]  pix_luma,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        field,
  output logic        tbl_we,
  output logic [9:0]  tbl_addr,
  output logic [7:0]  tbl_data,
  output logic        lut_done,
  output logic        busy,
  output logic        overrun,
  output logic [17:0] roi_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [8:0]          r_idx;
  logic [9:0]          r_wbase;
  logic [BIN_W-1:0]    r_pix_cnt;
  logic [BIN_W-1:0]    r_roi_cnt;
  logic                r_overrun;
  logic                r_p1_vld;
  logic [7:0]          r_p1_addr;
  logic                r_byp_vld;
  logic [BIN_W-1:0]    r_byp_dat;
  logic                r_rd_vld;
  logic [7:0]          r_rd_idx;
  logic [BIN_W-1:0]    r_cdf;
  logic [PROD_W-1:0]   r_prod;
  logic                r_out_vld;
  logic [7:0]          r_out_idx;
  logic                r_done;

  logic                w_in_roi;
  logic                w_hit;
  logic                w_last_wr;
  logic                w_ram_we;
  logic [7:0]          w_ram_waddr;
  logic [BIN_W-1:0]    w_ram_wdata;
  logic [7:0]          w_ram_raddr;
  logic [BIN_W-1:0]    w_ram_rdata;
  logic [BIN_W-1:0]    w_rd_fwd;
  logic [BIN_W-1:0]    w_cdf_sum;

  assign w_in_roi  = (pix_x >= ROI_X0) && (pix_x < ROI_X1) &&
                     (pix_y >= ROI_Y0) && (pix_y < ROI_Y1);
  assign w_hit     = (r_state == ACCUM) && pix_valid && !field && w_in_roi;
  assign w_last_wr = r_out_vld && (r_out_idx == 8'hFF);

  // A write landing in the same cycle as a read of that bin is returned in
  // place of the stale RAM word; this covers back-to-back equal pixels.
  assign w_rd_fwd  = r_byp_vld ? r_byp_dat : w_ram_rdata;
  assign w_cdf_sum = r_cdf + w_rd_fwd;

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_p1_addr;
    w_ram_wdata = w_rd_fwd + 18'd1;
    if (r_state == CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_idx[7:0];
      w_ram_wdata = '0;
    end else if (r_p1_vld) begin
      w_ram_we    = 1'b1;
    end
  end

  assign w_ram_raddr = (r_state == CDF) ? r_idx[7:0] : pix_luma;

  hist_ram #(
    .AW (8),
    .DW (BIN_W)
  ) u_hist_ram (
    .i_clk   (llck),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_idx[7:0] == 8'hFF) w_state_nxt = IDLE;
      IDLE:    if (frame_start)         w_state_nxt = ACCUM;
      ACCUM:   if (frame_end)           w_state_nxt = CDF;
      CDF:     if (w_last_wr)           w_state_nxt = CLEAR;
      default:                          w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge llck or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge llck or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_wbase   <= '0;
      r_pix_cnt <= '0;
      r_roi_cnt <= '0;
      r_overrun <= 1'b0;
      r_p1_vld  <= 1'b0;
      r_p1_addr <= '0;
      r_byp_vld <= 1'b0;
      r_byp_dat <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
      r_cdf     <= '0;
      r_prod    <= '0;
      r_out_vld <= 1'b0;
      r_out_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_p1_vld  <= w_hit;
      r_p1_addr <= pix_luma;
      r_byp_vld <= w_ram_we && (w_ram_waddr == w_ram_raddr);
      r_byp_dat <= w_ram_wdata;
      r_done    <= (r_state == CDF) && w_last_wr;

      if (frame_start && ((r_state == CLEAR) || (r_state == CDF))) begin
        r_overrun <= 1'b1;
      end

      // CDF read -> sum/product -> table write pipeline
      r_rd_vld  <= (r_state == CDF) && !r_idx[8];
      r_rd_idx  <= r_idx[7:0];
      r_out_vld <= r_rd_vld;
      r_out_idx <= r_rd_idx;
      if (r_rd_vld) begin
        r_cdf  <= w_cdf_sum;
        r_prod <= PROD_W'(w_cdf_sum) * PROD_W'(255);
      end

      case (r_state)
        CLEAR: begin
          r_idx <= r_idx + 9'd1;
        end
        IDLE: begin
          if (frame_start) begin
            r_wbase   <= flag ? BANK_STRIDE : 10'd0;
            r_pix_cnt <= '0;
          end
        end
        ACCUM: begin
          if (frame_end) begin
            r_roi_cnt <= r_pix_cnt;
            r_idx     <= '0;
            r_cdf     <= '0;
          end else if (frame_start) begin
            r_wbase   <= flag ? BANK_STRIDE : 10'd0;
            r_pix_cnt <= '0;
          end else if (w_hit && (r_pix_cnt != {BIN_W{1'b1}})) begin
            r_pix_cnt <= r_pix_cnt + 18'd1;
          end
        end
        CDF: begin
          if (w_last_wr) begin
            r_idx <= '0;
          end else if (!r_idx[8]) begin
            r_idx <= r_idx + 9'd1;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign tbl_we    = r_out_vld;
  assign tbl_addr  = r_wbase + {2'b00, r_out_idx};
  assign tbl_data  = sat_gray(r_prod, ROI_SHIFT);
  assign lut_done  = r_done;
  assign busy      = (r_state == CLEAR) || (r_state == CDF);
  assign overrun   = r_overrun;
  assign roi_count = r_roi_cnt;

endmodule

// File: tb/tb_gray_lut_builder.sv
// Self-checking bench for gray_lut_builder on a reduced 64x16 ROI so every
// frame (pixels, table computation, clear) stays short.
module tb_gray_lut_builder;

  localparam int X0    = 104;
  localparam int X1    = 168;
  localparam int Y0    = 30;
  localparam int Y1    = 46;
  localparam int SHIFT = 10;

  logic        llck        = 1'b0;
  logic        reset       = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end   = 1'b0;
  logic        flag        = 1'b0;
  logic        pix_valid   = 1'b0;
  logic [7:0]  pix_luma    = 8'd0;
  logic [9:0]  pix_x       = 10'd0;
  logic [9:0]  pix_y       = 10'd0;
  logic        field       = 1'b0;
  logic        tbl_we;
  logic [9:0]  tbl_addr;
  logic [7:0]  tbl_data;
  logic        lut_done;
  logic        busy;
  logic        overrun;
  logic [17:0] roi_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int mhist[256];
  int mcnt;
  bit model_on = 1'b0;
  int last_tab[256];
  int last_addr[256];

  gray_lut_builder #(
    .ROI_X0      (10'd104),
    .ROI_X1      (10'd168),
    .ROI_Y0      (10'd30),
    .ROI_Y1      (10'd46),
    .ROI_SHIFT   (10),
    .BANK_STRIDE (10'd512)
  ) dut (
    .llck        (llck),
    .reset       (reset),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .flag        (flag),
    .pix_valid   (pix_valid),
    .pix_luma    (pix_luma),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .field       (field),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .lut_done    (lut_done),
    .busy        (busy),
    .overrun     (overrun),
    .roi_count   (roi_count)
  );

  always #5 llck = ~llck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge llck);
    #1;
  endtask

  function automatic bit in_roi(input int x, input int y);
    return (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
  endfunction

  task automatic send_pix(input int x, input int y, input bit f, input int l, input int gap);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    field     = f;
    pix_luma  = 8'(l);
    tick();
    pix_valid = 1'b0;
    if (model_on && !f && in_roi(x, y)) begin
      mhist[l]++;
      mcnt++;
    end
    repeat (gap) tick();
  endtask

  // mode: 0 all 0x80, 1 half 0x10 / half 0xF0, 2 all 0xFF, 3 quarter 0x40 rest 0, 4 random
  // gapmode: 0 every other cycle, 1 back-to-back, 2 random spacing
  task automatic send_roi(input int mode, input int gapmode);
    int k = 0;
    for (int y = Y0; y < Y1; y++) begin
      for (int x = X0; x < X1; x++) begin
        int l;
        int g;
        case (mode)
          0:       l = 128;
          1:       l = (k < 512) ? 16 : 240;
          2:       l = 255;
          3:       l = (k < 256) ? 64 : 0;
          default: l = int'($urandom_range(0, 255));
        endcase
        g = (gapmode == 0) ? 1 : (gapmode == 1) ? 0 : int'($urandom_range(0, 2));
        send_pix(x, y, 1'b0, l, g);
        k++;
      end
    end
  endtask

  task automatic send_noise();
    for (int k = 0; k < 16; k++) begin
      send_pix(X0 - 1, Y0 + k, 1'b0, 0, 1);
      send_pix(X1, Y0 + k, 1'b0, 0, 1);
      send_pix(X0 + k, Y1, 1'b0, 0, 1);
      send_pix(X0 + k, Y0 - 1, 1'b0, 0, 1);
      send_pix(X0 + k, Y0 + k, 1'b1, 0, 1);
    end
  endtask

  task automatic start_frame(input bit f);
    for (int i = 0; i < 256; i++) mhist[i] = 0;
    mcnt        = 0;
    flag        = f;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_on    = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 700; k++) begin
      @(negedge llck);
      if (busy === 1'b0) break;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge llck);
      if (busy !== 1'b1) break;
      n++;
    end
    check(tag, n, 256);
  endtask

  // Ends the frame, collects the table writes and compares them with the
  // equalisation table derived from the bench histogram.
  task automatic finish_frame(input int wbase, input int fs_at, input int rst_at);
    int exp_tab[256];
    int cdf = 0;
    int nwr = 0;
    int first = -1;
    int last = -1;
    int done = -1;
    bit aborted = 1'b0;
    for (int i = 0; i < 256; i++) begin
      int g;
      cdf += mhist[i];
      g = (cdf * 255) >> SHIFT;
      exp_tab[i] = (g > 255) ? 255 : g;
    end
    check("tbl_we_quiet_in_accum", tbl_we, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    model_on  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge llck);
      frame_start = (cyc == fs_at);
      if (tbl_we === 1'b1) begin
        if (nwr == 0) first = cyc;
        last = cyc;
        if (nwr < 256) begin
          last_tab[nwr]  = int'(tbl_data);
          last_addr[nwr] = int'(tbl_addr);
        end
        if (nwr == rst_at) begin
          reset = 1'b1;
          #1;
          check("reset_drops_tbl_we", tbl_we, 0);
          check("reset_busy", busy, 1);
          aborted = 1'b1;
        end
        nwr++;
      end
      if (lut_done === 1'b1 && done < 0) done = cyc;
      if (aborted || done >= 0) break;
    end
    frame_start = 1'b0;
    if (!aborted) begin
      check("write_count", nwr, 256);
      check("first_write_cycle", first, 2);
      check("last_write_cycle", last, 257);
      check("frame_end_to_lut_done", done + 1, 259);
      check("roi_count", roi_count, mcnt);
      for (int i = 0; i < 256; i++) begin
        check($sformatf("tbl_addr[%0d]", i), last_addr[i], wbase + i);
        check($sformatf("tbl_data[%0d]", i), last_tab[i], exp_tab[i]);
      end
    end
  endtask

  initial begin
    bit fr;
    repeat (3) tick();
    check("rst_tbl_we", tbl_we, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_tbl_data", tbl_data, 0);
    check("rst_lut_done", lut_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_roi_count", roi_count, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    count_clear("clear_cycles_after_reset");

    // Pixels while idle must not be counted.
    for (int k = 0; k < 16; k++) send_pix(X0 + k, Y0, 1'b0, 0, 1);
    start_frame(1'b0);
    send_roi(0, 0);
    finish_frame(0, -1, -1);
    check("A_entry_7F", last_tab[127], 0);
    check("A_entry_80", last_tab[128], 255);
    check("A_roi_count", roi_count, 1024);

    wait_idle();
    start_frame(1'b1);
    send_roi(1, 0);
    finish_frame(512, -1, -1);
    check("B_first_addr", last_addr[0], 512);
    check("B_entry_0F", last_tab[15], 0);
    check("B_entry_10", last_tab[16], 127);
    check("B_entry_EF", last_tab[239], 127);
    check("B_entry_F0", last_tab[240], 255);

    wait_idle();
    start_frame(1'b0);
    send_noise();
    send_roi(2, 0);
    send_noise();
    finish_frame(0, -1, -1);
    check("C_roi_count", roi_count, 1024);
    check("C_entry_FE", last_tab[254], 0);
    check("C_entry_FF", last_tab[255], 255);

    wait_idle();
    start_frame(1'b1);
    send_roi(3, 1);
    finish_frame(512, -1, -1);
    check("D_entry_3F", last_tab[63], 191);
    check("D_entry_40", last_tab[64], 255);

    wait_idle();
    check("overrun_before", overrun, 0);
    fr = 1'($urandom_range(0, 1));
    start_frame(fr);
    send_roi(4, 2);
    finish_frame(fr ? 512 : 0, 100, -1);
    check("overrun_set", overrun, 1);

    wait_idle();
    fr = 1'($urandom_range(0, 1));
    start_frame(fr);
    send_roi(4, 0);
    finish_frame(fr ? 512 : 0, -1, -1);
    check("overrun_sticky", overrun, 1);

    wait_idle();
    start_frame(1'b1);
    send_roi(4, 1);
    finish_frame(512, -1, 37);
    tick();
    reset = 1'b0;
    count_clear("clear_cycles_after_abort");
    check("abort_overrun_cleared", overrun, 0);
    check("abort_roi_count", roi_count, 0);
    check("abort_lut_done", lut_done, 0);

    start_frame(1'b0);
    send_roi(4, 2);
    finish_frame(0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_lut_builder.md
Name: gray_lut_builder

Overview:
- Downstream companion of the SAA7113 capture stage. Taps the capture stage's luma stream and builds a 256-bin histogram over the 512x256 ROI of field 0.
- At frame end, computes the histogram-equalisation gray table and writes it into the inactive bank of the gray-table dual-port RAM. The capture stage reads that bank as data_4newtable on the next frame.

Parameters:
- ROI_X0, 104, first counted horizontal position (inclusive)
- ROI_X1, 616, horizontal end (exclusive)
- ROI_Y0, 30, first counted line (inclusive)
- ROI_Y1, 286, line end (exclusive)
- ROI_SHIFT, 17, log2 of ROI pixel count (512*256)
- BANK_STRIDE, 512, table address offset between ping-pong banks

Ports:
- llck  in  1  video clock, 27 MHz
- reset  in  1  asynchronous reset, active-high
- frame_start  in  1  one-cycle pulse when capture toggles flag
- frame_end  in  1  one-cycle pulse at end of field 1 (capture returns to idle)
- flag  in  1  capture ping-pong flag; sampled on frame_start
- pix_valid  in  1  luma byte strobe, at most every other cycle
- pix_luma  in  8  luma value
- pix_x  in  10  horizontal counter
- pix_y  in  10  line counter
- field  in  1  0 = odd field
- tbl_we  out  1  gray-table write strobe
- tbl_addr  out  10  gray-table write address
- tbl_data  out  8  new gray level
- lut_done  out  1  one-cycle pulse after the last table write
- busy  out  1  high in any state except IDLE and ACCUM
- overrun  out  1  sticky; a frame_start arrived while busy
- roi_count  out  18  ROI pixels counted in the last frame

Behaviour:
- Reset (asynchronous, active-high):
  - State = CLEAR, clear index = 0.
  - tbl_we=0, tbl_addr=0, tbl_data=0, lut_done=0, overrun=0, roi_count=0, busy=1.
  - Histogram contents are undefined after reset, so the block always clears first. A reset mid-operation aborts all writes immediately.
- CLEAR: writes 0 to bin i on each cycle, i = 0..255 (256 cycles), then goes to IDLE.
- IDLE: on frame_start, latches wbase = flag ? BANK_STRIDE : 0, clears the pixel counter, and goes to ACCUM. The capture stage reads bank (!flag)*512, so the builder writes the bank the capture stage is not currently reading.
- ACCUM (pixel counting):
  - A pixel counts when pix_valid & field==0 & ROI_X0<=pix_x<ROI_X1 & ROI_Y0<=pix_y<ROI_Y1.
  - Each counted pixel does a read-modify-write on bin[pix_luma]: read in cycle n, write bin+1 in cycle n+1.
  - If a counted pixel arrives in cycle n+1 with the same luma, the pending write value is forwarded to it, so no increment is lost even back-to-back.
  - The 18-bit pixel counter saturates at 2^18-1.
- ACCUM exit: frame_end -> CDF, and roi_count <= pixel counter. A frame_start during ACCUM (frame_end missed, e.g. capture error) restarts ACCUM from the same reset point, without a clear.
- CDF (table computation):
  - Reads bins i = 0..255 in order and keeps an 18-bit inclusive running sum cdf.
  - Product p = cdf*255 (26 bits) is registered.
  - tbl_data = min(255, p >> ROI_SHIFT), tbl_addr = wbase + i, tbl_we = 1.
  - The first write occurs 2 cycles after CDF entry; 256 consecutive writes follow.
  - lut_done pulses the cycle after the write of i=255. Next state: CLEAR.
  - Total frame_end to lut_done = 259 cycles; the full busy period is about 516 cycles, well inside vertical blanking.
- Boundaries:
  - A frame_start during CDF or CLEAR sets overrun and is ignored. The next frame_start seen in IDLE is served.
  - pix_valid outside ACCUM is ignored.
  - tbl_we is never asserted outside CDF.
  - overrun clears only on reset.

Decomposition:
- Shared package gray_lut_pkg:
  - state encoding: CLEAR, IDLE, ACCUM, CDF
  - ROI defaults, ROI_SHIFT, BANK_STRIDE
  - bin width constant (18)
- Sub-module hist_ram: 256x18 single-clock RAM with 1-cycle registered read and synchronous write, so it maps to block RAM.

Test Plan:
- After reset, frame_start(flag=0), then the 131072 ROI pixels of field 0 all at 0x80, then frame_end -> tbl_addr 0..127 carry 0x00, 128..255 carry 0xFF; lut_done occurs 259 cycles after frame_end; roi_count=131072.
- Half the ROI pixels at 0x10, half at 0xF0, with flag=1 -> writes go to addresses 512..767; entries 0x00..0x0F = 0, 0x10..0xEF = 127, 0xF0..0xFF = 255.
- Pixels outside the ROI (pix_x=103, pix_y=286) and all field=1 pixels at 0x00, plus the ROI filled with 0xFF -> roi_count=131072; entries 0..254 = 0, entry 255 = 255.
- Back-to-back pix_valid on consecutive cycles, 4096 pixels all 0x40, rest 0x00 -> bin 0x40 = 4096 (checked via tbl_data step at 0x40: 0x3F entry = 247, 0x40 entry = 255).
- frame_start issued 100 cycles after frame_end -> overrun=1; the current table still completes with 256 writes; the next frame proceeds normally.
- reset asserted mid-CDF at i=37 -> tbl_we drops immediately; busy=1 for 256 CLEAR cycles; the next frame produces a correct table with no residual counts.
